// File: rtl/mips_pkg.sv
// mips_pkg: opcode/function encodings and enums shared by the execute stage
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI = 6'h0F, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                           OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_MFHI = 6'h10, F_MFLO = 6'h12,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT = 6'h2A, F_SLTU = 6'h2B;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO
    } alu_op_e;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/md_unit.sv
// md_unit: iterative shift-add multiplier / restoring divider owning the HI/LO registers
module md_unit import mips_pkg::*; #(
    parameter int BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int K = 32 / BITS;
    md_state_e state, state_nxt;
    logic [5:0] cnt;
    logic [63:0] p, p_src, p_nxt, prod;
    logic [31:0] m, m_src, a_abs, b_abs, quo, rem;
    logic is_div, neg_q, neg_r, dz, div_in, sgn_in, div_src, idle;
    function automatic logic [63:0] mul_step(input logic [63:0] x, input logic [31:0] y);
        logic [32:0] s;
        s = {1'b0, x[63:32]} + (x[0] ? {1'b0, y} : 33'd0);
        return {s, x[31:1]};
    endfunction
    function automatic logic [63:0] div_step(input logic [63:0] x, input logic [31:0] y);
        logic [32:0] r, rr;
        logic ge;
        r = x[63:31];
        ge = r >= {1'b0, y};
        rr = ge ? r - {1'b0, y} : r;
        return {rr[31:0], x[30:0], ge};
    endfunction
    always_ff @(posedge clk)
        if (rst) state <= MD_IDLE;
        else state <= state_nxt;
    always_comb
        state_nxt = state == MD_IDLE ? (start ? MD_BUSY : MD_IDLE) :
                    state == MD_BUSY ? (flush ? MD_IDLE : (cnt == 6'(K - 1) ? MD_DONE : MD_BUSY)) : MD_IDLE;
    always_comb stall = (state == MD_IDLE && start) || (state == MD_BUSY && !flush);
    // Operands are folded to magnitudes; signs are reapplied on the final edge.
    assign idle = state == MD_IDLE;
    assign div_in = op == MD_DIV || op == MD_DIVU;
    assign sgn_in = op == MD_MULT || op == MD_DIV;
    assign a_abs = (sgn_in && a[31]) ? -a : a;
    assign b_abs = (sgn_in && b[31]) ? -b : b;
    assign div_src = idle ? div_in : is_div;
    assign p_src = idle ? {32'b0, div_in ? a_abs : b_abs} : p;
    assign m_src = idle ? (div_in ? b_abs : a_abs) : m;
    always_comb begin
        p_nxt = p_src;
        for (int i = 0; i < BITS; i++) p_nxt = div_src ? div_step(p_nxt, m_src) : mul_step(p_nxt, m_src);
    end
    assign prod = neg_q ? -p_nxt : p_nxt;
    assign quo = neg_q ? -p_nxt[31:0] : p_nxt[31:0];
    assign rem = neg_r ? -p_nxt[63:32] : p_nxt[63:32];
    always_ff @(posedge clk)
        if (rst) begin
            {cnt, p, m, is_div, neg_q, neg_r, dz, hi, lo} <= '0;
        end else if (idle && start) begin
            cnt <= 6'd1;
            p <= p_nxt;
            m <= m_src;
            is_div <= div_in;
            neg_q <= sgn_in && (a[31] ^ b[31]);
            neg_r <= sgn_in && a[31];
            dz <= div_in && b == 32'd0;
        end else if (state == MD_BUSY && !flush) begin
            cnt <= cnt + 6'd1;
            p <= p_nxt;
            if (cnt == 6'(K - 1)) begin
                hi <= is_div ? rem : prod[63:32];
                lo <= is_div ? (dz ? 32'hFFFF_FFFF : quo) : prod[31:0];
            end
        end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with EX/MEM register; OVF_TRAP_EN enables signed-overflow trapping
module ex_stage import mips_pkg::*; #(
    parameter int MD_BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_id_ex,
    input  logic        flush_ex,
    input  logic [5:0]  opcode_id_ex,
    input  logic [5:0]  func_id_ex,
    input  logic        aluSrc_id_ex,
    input  logic        wr_en_reg_id_ex,
    input  logic [4:0]  wr_num_id_ex,
    input  logic        dm_rw_id_ex,
    input  logic [1:0]  dm_access_sz_id_ex,
    input  logic [31:0] rd0_data_id_ex,
    input  logic [31:0] rd1_data_id_ex,
    input  logic [15:0] imm_id_ex,
    input  logic [4:0]  shift_amount_id_ex,
    input  logic [31:0] pc_id_ex,
    output logic        stall_ex,
`ifdef OVF_TRAP_EN
    output logic        ovf_exc_ex_mem,
`endif
    output logic        valid_ex_mem,
    output logic [31:0] alu_result_ex_mem,
    output logic [31:0] st_data_ex_mem,
    output logic        wr_en_reg_ex_mem,
    output logic [4:0]  wr_num_ex_mem,
    output logic        dm_rw_ex_mem,
    output logic [1:0]  dm_access_sz_ex_mem,
    output logic [31:0] pc_ex_mem
);
    alu_op_e alu_op;
    md_op_e md_op;
    logic var_sh, zext, is_md, known, live, trap;
    logic [31:0] a, b, ext, sum, diff, result, hi, lo;
    logic [4:0] sh;
    always_comb begin
        alu_op = ALU_ADD;
        md_op = md_op_e'(func_id_ex[1:0]);
        {var_sh, zext, is_md} = '0;
        known = 1'b1;
        case (opcode_id_ex)
            OP_RTYPE:
                case (func_id_ex)
                    F_SLL: alu_op = ALU_SLL;
                    F_SRL: alu_op = ALU_SRL;
                    F_SRA: alu_op = ALU_SRA;
                    F_SLLV: begin alu_op = ALU_SLL; var_sh = 1'b1; end
                    F_SRLV: begin alu_op = ALU_SRL; var_sh = 1'b1; end
                    F_SRAV: begin alu_op = ALU_SRA; var_sh = 1'b1; end
                    F_MFHI: alu_op = ALU_MFHI;
                    F_MFLO: alu_op = ALU_MFLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND: alu_op = ALU_AND;
                    F_OR: alu_op = ALU_OR;
                    F_XOR: alu_op = ALU_XOR;
                    F_NOR: alu_op = ALU_NOR;
                    F_SLT: alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    default: known = 1'b0;
                endcase
            OP_ADDI, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: alu_op = ALU_ADD;
            OP_SLTI: alu_op = ALU_SLT;
            OP_SLTIU: alu_op = ALU_SLTU;
            OP_ANDI: begin alu_op = ALU_AND; zext = 1'b1; end
            OP_ORI: begin alu_op = ALU_OR; zext = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; zext = 1'b1; end
            OP_LUI: alu_op = ALU_LUI;
            default: known = 1'b0;
        endcase
    end
    assign ext = zext ? {16'b0, imm_id_ex} : {{16{imm_id_ex[15]}}, imm_id_ex};
    assign a = rd0_data_id_ex;
    assign b = aluSrc_id_ex ? ext : rd1_data_id_ex;
    assign sum = a + b;
    assign diff = a - b;
    assign sh = var_sh ? rd0_data_id_ex[4:0] : shift_amount_id_ex;
    always_comb
        case (alu_op)
            ALU_SUB: result = diff;
            ALU_AND: result = a & b;
            ALU_OR: result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_LUI: result = {imm_id_ex, 16'b0};
            ALU_SLL: result = rd1_data_id_ex << sh;
            ALU_SRL: result = rd1_data_id_ex >> sh;
            ALU_SRA: result = $signed(rd1_data_id_ex) >>> sh;
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default: result = sum;
        endcase
`ifdef OVF_TRAP_EN
    // Only the trapping forms (ADD, ADDI, SUB) raise overflow; the U variants wrap silently.
    logic ovf_chk;
    assign ovf_chk = (opcode_id_ex == OP_RTYPE && (func_id_ex == F_ADD || func_id_ex == F_SUB)) || opcode_id_ex == OP_ADDI;
    assign trap = ovf_chk && (alu_op == ALU_SUB ? (a[31] != b[31] && diff[31] != a[31]) : (a[31] == b[31] && sum[31] != a[31]));
`else
    assign trap = 1'b0;
`endif
    assign live = valid_id_ex && !flush_ex && known && !is_md;
    md_unit #(.BITS(MD_BITS_PER_CYC)) u_md (
        .clk(clk), .rst(rst), .start(valid_id_ex && !flush_ex && is_md), .flush(flush_ex),
        .op(md_op), .a(rd0_data_id_ex), .b(rd1_data_id_ex), .stall(stall_ex), .hi(hi), .lo(lo)
    );
    always_ff @(posedge clk)
        if (rst) begin
            {valid_ex_mem, alu_result_ex_mem, st_data_ex_mem, wr_en_reg_ex_mem, wr_num_ex_mem,
             dm_rw_ex_mem, dm_access_sz_ex_mem, pc_ex_mem} <= '0;
`ifdef OVF_TRAP_EN
            ovf_exc_ex_mem <= 1'b0;
`endif
        end else begin
            valid_ex_mem <= live;
            alu_result_ex_mem <= result;
            st_data_ex_mem <= rd1_data_id_ex;
            wr_en_reg_ex_mem <= live && wr_en_reg_id_ex && !trap;
            wr_num_ex_mem <= live ? wr_num_id_ex : 5'd0;
            dm_rw_ex_mem <= live && dm_rw_id_ex;
            dm_access_sz_ex_mem <= live ? dm_access_sz_id_ex : 2'd0;
            pc_ex_mem <= live ? pc_id_ex : 32'd0;
`ifdef OVF_TRAP_EN
            ovf_exc_ex_mem <= live && trap;
`endif
        end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage (default MD_BITS_PER_CYC = 1, K = 32)
module tb_ex_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic valid_id_ex, flush_ex, aluSrc_id_ex, wr_en_reg_id_ex, dm_rw_id_ex;
    logic [5:0] opcode_id_ex, func_id_ex;
    logic [4:0] wr_num_id_ex, shift_amount_id_ex;
    logic [1:0] dm_access_sz_id_ex;
    logic [31:0] rd0_data_id_ex, rd1_data_id_ex, pc_id_ex;
    logic [15:0] imm_id_ex;
    logic stall_ex, valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem;
    logic [31:0] alu_result_ex_mem, st_data_ex_mem, pc_ex_mem;
    logic [4:0] wr_num_ex_mem;
    logic [1:0] dm_access_sz_ex_mem;
`ifdef OVF_TRAP_EN
    logic ovf_exc_ex_mem;
`endif
    int checks = 0, errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .valid_id_ex(valid_id_ex), .flush_ex(flush_ex),
        .opcode_id_ex(opcode_id_ex), .func_id_ex(func_id_ex), .aluSrc_id_ex(aluSrc_id_ex),
        .wr_en_reg_id_ex(wr_en_reg_id_ex), .wr_num_id_ex(wr_num_id_ex), .dm_rw_id_ex(dm_rw_id_ex),
        .dm_access_sz_id_ex(dm_access_sz_id_ex), .rd0_data_id_ex(rd0_data_id_ex),
        .rd1_data_id_ex(rd1_data_id_ex), .imm_id_ex(imm_id_ex), .shift_amount_id_ex(shift_amount_id_ex),
        .pc_id_ex(pc_id_ex), .stall_ex(stall_ex),
`ifdef OVF_TRAP_EN
        .ovf_exc_ex_mem(ovf_exc_ex_mem),
`endif
        .valid_ex_mem(valid_ex_mem), .alu_result_ex_mem(alu_result_ex_mem), .st_data_ex_mem(st_data_ex_mem),
        .wr_en_reg_ex_mem(wr_en_reg_ex_mem), .wr_num_ex_mem(wr_num_ex_mem), .dm_rw_ex_mem(dm_rw_ex_mem),
        .dm_access_sz_ex_mem(dm_access_sz_ex_mem), .pc_ex_mem(pc_ex_mem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic src,
                         input logic [31:0] ra, input logic [31:0] rb, input logic [15:0] im, input logic [4:0] sa);
        valid_id_ex = 1'b1; flush_ex = 1'b0; opcode_id_ex = op; func_id_ex = fn; aluSrc_id_ex = src;
        wr_en_reg_id_ex = 1'b1; wr_num_id_ex = 5'd9; dm_rw_id_ex = 1'b0; dm_access_sz_id_ex = 2'b10;
        rd0_data_id_ex = ra; rd1_data_id_ex = rb; imm_id_ex = im; shift_amount_id_ex = sa;
        pc_id_ex = pc_id_ex + 32'd4;
    endtask

    task automatic bubble();
        valid_id_ex = 1'b0; flush_ex = 1'b0; opcode_id_ex = 6'h00; func_id_ex = 6'h21;
    endtask

    // Holds the MD instruction while stall_ex is high, then steps through the DONE cycle.
    task automatic md_run(output int n);
        #1;
        n = 0;
        while (stall_ex === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        tick();
    endtask

    task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        drive(6'h00, 6'h10, 1'b0, 0, 0, 0, 0);
        tick();
        checks++;
        if (alu_result_ex_mem !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi: got %h expected %h", tag, alu_result_ex_mem, exp_hi);
        end
        drive(6'h00, 6'h12, 1'b0, 0, 0, 0, 0);
        tick();
        checks++;
        if (alu_result_ex_mem !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo: got %h expected %h", tag, alu_result_ex_mem, exp_lo);
        end
    endtask

    task automatic test_reset();
        bubble();
        pc_id_ex = 32'h100;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({stall_ex, valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem, alu_result_ex_mem, pc_ex_mem, wr_num_ex_mem} !== '0) begin
            errors++;
            $display("FAIL reset: stall=%b valid=%b wr=%b rw=%b res=%h pc=%h expected all 0",
                     stall_ex, valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem, alu_result_ex_mem, pc_ex_mem);
        end
        rst = 1'b0;
        read_hilo(32'd0, 32'd0, "reset_hilo");
    endtask

    task automatic test_alu();
        logic [5:0] op [24] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D,
                                6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h00};
        logic [5:0] fn [24] = '{6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 0, 0, 0,
                                0, 0, 0, 0, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h06, 0, 6'h21};
        logic [31:0] ra [24] = '{5, 5, 32'h10, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFF0000, 0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 10, 32'hFFFFFFFF, 0, 32'hFFFF0000, 32'hFFFFFFFE, 5, 0, 0, 0, 0, 36, 32'h1F, 32'h21,
                                 32'h1000, 32'hFFFFFFFF};
        logic [31:0] rb [24] = '{7, 7, 1, 32'hFF00FF00, 32'h000000FF, 32'h0F0F0F0F, 32'h0F0F0F0F, 1, 1, 0, 0, 0,
                                 0, 0, 0, 0, 1, 32'h80000000, 32'h80000000, 3, 32'hF0000000, 8, 0, 2};
        logic [15:0] im [24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16'h8001, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                 16'h1234, 0, 0, 0, 0, 0, 0, 16'hFFFC, 0};
        logic [4:0] sa [24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 4, 4, 0, 0, 0, 0, 0};
        logic [31:0] ex [24] = '{12, 32'hFFFFFFFE, 32'hF, 32'hF000F000, 32'h0F0F00FF, 32'hF0F00F0F, 32'hF0F0F0F0, 1, 0,
                                 9, 32'h00008001, 32'h00008000, 32'hFFFFFFFF, 1, 1, 32'h12340000, 32'h80000000,
                                 32'h08000000, 32'hF8000000, 32'h30, 32'hFFFFFFFF, 4, 32'hFFC, 1};
        for (int i = 0; i < 24; i++) begin
            drive(op[i], fn[i], op[i] != 6'h00, ra[i], rb[i], im[i], sa[i]);
            tick();
            checks++;
            if (alu_result_ex_mem !== ex[i] || valid_ex_mem !== 1'b1 || wr_en_reg_ex_mem !== 1'b1) begin
                errors++;
                $display("FAIL alu[%0d]: got res=%h valid=%b wr=%b expected res=%h valid=1 wr=1",
                         i, alu_result_ex_mem, valid_ex_mem, wr_en_reg_ex_mem, ex[i]);
            end
            if (i == 0) begin
                checks++;
                if (pc_ex_mem !== pc_id_ex || wr_num_ex_mem !== 5'd9) begin
                    errors++;
                    $display("FAIL add_fields: got pc=%h num=%0d expected pc=%h num=9", pc_ex_mem, wr_num_ex_mem, pc_id_ex);
                end
            end
        end
    endtask

    task automatic test_bubble();
        drive(6'h2B, 0, 1'b1, 32'h2000, 32'hCAFEF00D, 16'h0008, 0);
        dm_rw_id_ex = 1'b1;
        tick();
        checks++;
        if (valid_ex_mem !== 1'b1 || dm_rw_ex_mem !== 1'b1 || alu_result_ex_mem !== 32'h2008 || st_data_ex_mem !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL store: got valid=%b rw=%b addr=%h data=%h expected 1 1 00002008 cafef00d",
                     valid_ex_mem, dm_rw_ex_mem, alu_result_ex_mem, st_data_ex_mem);
        end
        for (int k = 0; k < 4; k++) begin
            drive(k == 2 ? 6'h3F : 6'h00, k == 3 ? 6'h01 : 6'h20, 1'b0, 1, 2, 0, 0);
            dm_rw_id_ex = 1'b1;
            valid_id_ex = k != 0;
            flush_ex = k == 1;
            tick();
            checks++;
            if (valid_ex_mem !== 1'b0 || wr_en_reg_ex_mem !== 1'b0 || dm_rw_ex_mem !== 1'b0) begin
                errors++;
                $display("FAIL bubble[%0d]: got valid=%b wr=%b rw=%b expected 0 0 0",
                         k, valid_ex_mem, wr_en_reg_ex_mem, dm_rw_ex_mem);
            end
        end
    endtask

    task automatic test_mult();
        int n;
        drive(6'h00, 6'h18, 1'b0, 32'hFFFFFFFF, 2, 0, 0);
        md_run(n);
        checks++;
        if (n !== 32 || valid_ex_mem !== 1'b0 || wr_en_reg_ex_mem !== 1'b0) begin
            errors++;
            $display("FAIL mult_stall: got cycles=%0d valid=%b wr=%b expected 32 0 0", n, valid_ex_mem, wr_en_reg_ex_mem);
        end
        read_hilo(32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        drive(6'h00, 6'h19, 1'b0, 32'h10000, 32'h10000, 0, 0);
        md_run(n);
        read_hilo(32'd1, 32'd0, "multu");
    endtask

    task automatic test_div();
        logic [5:0] fn [4] = '{6'h1B, 6'h1A, 6'h1A, 6'h1A};
        logic [31:0] ra [4] = '{7, 32'hFFFFFFF9, 32'hFFFFFFFB, 32'h80000000};
        logic [31:0] rb [4] = '{0, 2, 0, 32'hFFFFFFFF};
        logic [31:0] eh [4] = '{7, 32'hFFFFFFFF, 32'hFFFFFFFB, 0};
        logic [31:0] el [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        int n;
        for (int i = 0; i < 4; i++) begin
            drive(6'h00, fn[i], 1'b0, ra[i], rb[i], 0, 0);
            md_run(n);
            checks++;
            if (n !== 32) begin
                errors++;
                $display("FAIL div_stall[%0d]: got cycles=%0d expected 32", i, n);
            end
            read_hilo(eh[i], el[i], $sformatf("div%0d", i));
        end
    endtask

    task automatic test_flush();
        drive(6'h00, 6'h18, 1'b0, 3, 3, 0, 0);
        flush_ex = 1'b1;
        #1;
        checks++;
        if (stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got stall=%b expected 0", stall_ex);
        end
        tick();
        bubble();
        #1;
        checks++;
        if (stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_start: got stall=%b expected 0", stall_ex);
        end
        drive(6'h00, 6'h19, 1'b0, 3, 3, 0, 0);
        repeat (5) tick();
        flush_ex = 1'b1;
        #1;
        checks++;
        if (stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: got stall=%b expected 0", stall_ex);
        end
        tick();
        bubble();
        #1;
        checks++;
        if (stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort: got stall=%b expected 0", stall_ex);
        end
        read_hilo(32'd0, 32'h80000000, "flush_keep");
    endtask

    task automatic test_reset_mid_div();
        drive(6'h00, 6'h1A, 1'b0, 32'hFFFFFFF9, 2, 0, 0);
        repeat (10) tick();
        checks++;
        if (stall_ex !== 1'b1) begin
            errors++;
            $display("FAIL rst_div_busy: got stall=%b expected 1", stall_ex);
        end
        rst = 1'b1;
        bubble();
        tick();
        rst = 1'b0;
        checks++;
        if ({stall_ex, valid_ex_mem, wr_en_reg_ex_mem, alu_result_ex_mem, pc_ex_mem} !== '0) begin
            errors++;
            $display("FAIL rst_div: got stall=%b valid=%b wr=%b res=%h pc=%h expected all 0",
                     stall_ex, valid_ex_mem, wr_en_reg_ex_mem, alu_result_ex_mem, pc_ex_mem);
        end
        read_hilo(32'd0, 32'd0, "rst_div");
    endtask

    task automatic test_ovf();
        logic [5:0] op [3] = '{6'h00, 6'h00, 6'h00};
        logic [5:0] fn [3] = '{6'h20, 6'h21, 6'h22};
        logic [31:0] ra [3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] rb [3] = '{1, 1, 1};
        logic [31:0] ex [3] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        logic exp_wr, exp_ovf;
        for (int i = 0; i < 3; i++) begin
            drive(op[i], fn[i], 1'b0, ra[i], rb[i], 0, 0);
            tick();
`ifdef OVF_TRAP_EN
            exp_ovf = i != 1;
            exp_wr = i == 1;
            checks++;
            if (ovf_exc_ex_mem !== exp_ovf) begin
                errors++;
                $display("FAIL ovf_exc[%0d]: got %b expected %b", i, ovf_exc_ex_mem, exp_ovf);
            end
`else
            exp_wr = 1'b1;
            exp_ovf = 1'b0;
`endif
            checks++;
            if (wr_en_reg_ex_mem !== exp_wr || valid_ex_mem !== 1'b1 || alu_result_ex_mem !== ex[i]) begin
                errors++;
                $display("FAIL ovf[%0d]: got wr=%b valid=%b res=%h expected wr=%b valid=1 res=%h (ovf=%b)",
                         i, wr_en_reg_ex_mem, valid_ex_mem, alu_result_ex_mem, exp_wr, ex[i], exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bubble();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid_div();
        test_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
